// File: rtl/modexp_sequencer.sv
// modexp_sequencer
// Control sequencer for B^E mod N using left-to-right binary square-and-multiply.
// It drives an external modular multiplier through a start/done handshake. It
// also selects the operand pair (square R*R, or multiply R*B) and strobes the
// result register init and writeback. It performs no arithmetic of its own.
//
// Optional feature macro: SKIP_LEADING_ZEROS_EN
//   When defined, a SCAN state walks past the leading zero bits of the exponent
//   at one cycle per bit. The first set bit then issues a multiply directly,
//   because squaring R=1 would be wasted work.
//   When undefined, every one of the EXP_W bits is processed starting from the MSB.
//
// All outputs are registered and Moore-decoded. Each output register is loaded
// from the next-state value, so a strobe is high during exactly the cycle in
// which the FSM occupies the corresponding state.

module modexp_sequencer #(
  parameter int EXP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [EXP_W-1:0] exponent,
  input  logic             mm_done,
  output logic             mm_start,
  output logic             mm_op,
  output logic             r_init,
  output logic             r_we,
  output logic             busy,
  output logic             done
);

  // Bit-index counter width. A floor of one bit keeps degenerate widths legal.
  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(EXP_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  // State encoding
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_INIT      = 4'd1;
  localparam logic [3:0] ST_SQ_ISSUE  = 4'd2;
  localparam logic [3:0] ST_SQ_WAIT   = 4'd3;
  localparam logic [3:0] ST_SQ_WB     = 4'd4;
  localparam logic [3:0] ST_MUL_ISSUE = 4'd5;
  localparam logic [3:0] ST_MUL_WAIT  = 4'd6;
  localparam logic [3:0] ST_MUL_WB    = 4'd7;
  localparam logic [3:0] ST_NEXT      = 4'd8;
  localparam logic [3:0] ST_FINISH    = 4'd9;
`ifdef SKIP_LEADING_ZEROS_EN
  localparam logic [3:0] ST_SCAN      = 4'd10;
`endif

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [EXP_W-1:0] e_reg;
  logic             cur_bit;

  // The exponent bit that is currently being processed.
  assign cur_bit = e_reg[idx];

  // Next-state and bit-index logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_INIT;
          idx_nxt   = IDX_MSB;
        end
      end
      ST_INIT: begin
`ifdef SKIP_LEADING_ZEROS_EN
        state_nxt = ST_SCAN;
`else
        state_nxt = ST_SQ_ISSUE;
`endif
      end
`ifdef SKIP_LEADING_ZEROS_EN
      ST_SCAN: begin
        // R is still 1 here, so squaring it would change nothing. Skip straight
        // to the multiply for the first set bit.
        if (cur_bit) begin
          state_nxt = ST_MUL_ISSUE;
        end else if (idx == '0) begin
          state_nxt = ST_FINISH;
        end else begin
          idx_nxt = idx - IDX_ONE;
        end
      end
`endif
      ST_SQ_ISSUE:  state_nxt = ST_SQ_WAIT;
      ST_SQ_WAIT: begin
        if (mm_done) state_nxt = ST_SQ_WB;
      end
      ST_SQ_WB:     state_nxt = cur_bit ? ST_MUL_ISSUE : ST_NEXT;
      ST_MUL_ISSUE: state_nxt = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (mm_done) state_nxt = ST_MUL_WB;
      end
      ST_MUL_WB:    state_nxt = ST_NEXT;
      ST_NEXT: begin
        // Leave at bit 0 rather than decrementing, so idx never wraps.
        if (idx == '0) begin
          state_nxt = ST_FINISH;
        end else begin
          idx_nxt   = idx - IDX_ONE;
          state_nxt = ST_SQ_ISSUE;
        end
      end
      ST_FINISH:    state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State, index and registered Moore outputs, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= IDX_MSB;
      mm_start <= 1'b0;
      mm_op    <= 1'b0;
      r_init   <= 1'b0;
      r_we     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      mm_start <= (state_nxt == ST_SQ_ISSUE) || (state_nxt == ST_MUL_ISSUE);
      mm_op    <= (state_nxt == ST_MUL_ISSUE) || (state_nxt == ST_MUL_WAIT) ||
                  (state_nxt == ST_MUL_WB);
      r_init   <= (state_nxt == ST_INIT);
      r_we     <= (state_nxt == ST_SQ_WB) || (state_nxt == ST_MUL_WB);
      busy     <= (state_nxt != ST_IDLE);
      done     <= (state_nxt == ST_FINISH);
    end
  end

  // Exponent capture. It loads only when a start is accepted, so a start that
  // arrives while busy leaves the operand untouched.
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && start) begin
      e_reg <= exponent;
    end
  end

endmodule

// File: tb/tb_modexp_sequencer.sv
// Testbench for modexp_sequencer (EXP_W=4). A behavioural multiplier answers
// each mm_start after a chosen latency. A reference model derives the expected
// operation list and done cycle from the exponent bits.
`timescale 1ns/1ps

module tb_modexp_sequencer;

  localparam int EXP_W = 4;
`ifdef SKIP_LEADING_ZEROS_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [EXP_W-1:0] exponent = '0;
  logic             mm_done = 1'b0;
  logic             mm_start, mm_op, r_init, r_we, busy, done;

  modexp_sequencer #(.EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .exponent(exponent), .mm_done(mm_done),
    .mm_start(mm_start), .mm_op(mm_op), .r_init(r_init), .r_we(r_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model results
  bit exp_ops[$];
  int exp_done;

  // Observations from the last run
  bit       obs_ops[$];
  int       obs_done_cyc, obs_nstart, obs_nwe, obs_init_cyc, obs_ninit;
  int       obs_busy_gap, obs_unstable, obs_misaligned;
  int       obs_timeout;
  logic     obs_busy_after, obs_done_after;
  logic [5:0] obs_rst_outs;
  bit       obs_aborted;

  // Multiplier latency for the k-th issued operation
  function automatic int op_lat(input int k, input int fixed_l, input bit alt);
    if (alt) return (k % 2 == 0) ? 1 : 7;
    return fixed_l;
  endfunction

  function automatic int pack_q(input bit q[$]);
    int v = 0;
    foreach (q[i]) v = (v << 1) | int'(q[i]);
    return v | (q.size() << 16);
  endfunction

  // Reference model. From the MSB down, each processed bit contributes a square
  // (0), plus a multiply (1) when the bit is set, plus one bookkeeping cycle.
  // With skipping on, leading zeros cost one scan cycle each. The first set bit
  // costs one scan cycle and contributes a multiply only.
  task automatic model_run(input logic [EXP_W-1:0] e, input int fixed_l, input bit alt);
    int scan_c = 0;
    int nbits = 0;
    bit seen = !SKIP;
    exp_ops.delete();
    for (int i = EXP_W - 1; i >= 0; i--) begin
      if (!seen) begin
        scan_c++;
        if (e[i]) begin
          seen = 1'b1;
          exp_ops.push_back(1'b1);
          nbits++;
        end
        continue;
      end
      exp_ops.push_back(1'b0);
      if (e[i]) exp_ops.push_back(1'b1);
      nbits++;
    end
    exp_done = 2 + scan_c + nbits;
    for (int k = 0; k < exp_ops.size(); k++) exp_done += op_lat(k, fixed_l, alt) + 2;
  endtask

  // Runs one exponentiation starting at the current negedge, which is cycle 0.
  // It collects observations only and makes no comparisons.
  task automatic run_exp(input logic [EXP_W-1:0] e, input int fixed_l, input bit alt,
                         input bit spur, input bit start_busy, input bit rst_mulwait);
    int cyc, due, k;
    bit cur_op, in_op, md;
    obs_ops.delete();
    obs_done_cyc = -1; obs_nstart = 0; obs_nwe = 0; obs_init_cyc = -1; obs_ninit = 0;
    obs_busy_gap = 0; obs_unstable = 0; obs_misaligned = 0; obs_timeout = 0;
    obs_busy_after = 1'bx; obs_done_after = 1'bx; obs_rst_outs = 'x; obs_aborted = 0;
    if (spur) begin
      mm_done = 1'b1;
      @(negedge clk);
      mm_done = 1'b0;
    end
    start = 1'b1;
    exponent = e;
    @(negedge clk);
    start = 1'b0;
    exponent = EXP_W'($urandom);
    cyc = 1; due = -10; k = 0; cur_op = 0; in_op = 0;
    while (cyc < 2000) begin
      if (mm_start === 1'b1) begin
        obs_ops.push_back(mm_op);
        due = cyc + op_lat(k, fixed_l, alt);
        k++;
        cur_op = mm_op;
        in_op = 1'b1;
        obs_nstart++;
      end
      if (in_op && mm_op !== cur_op) obs_unstable++;
      if (r_we === 1'b1) begin
        obs_nwe++;
        if (cyc != due + 1) obs_misaligned++;
        in_op = 1'b0;
      end
      if (r_init === 1'b1) begin
        obs_ninit++;
        obs_init_cyc = cyc;
      end
      if (busy !== 1'b1) obs_busy_gap++;
      if (done === 1'b1) begin
        obs_done_cyc = cyc;
        mm_done = 1'b0;
        start = 1'b0;
        @(negedge clk);
        obs_busy_after = busy;
        obs_done_after = done;
        return;
      end
      if (rst_mulwait && in_op && cur_op && mm_op === 1'b1 && mm_start !== 1'b1 && r_we !== 1'b1) begin
        rst = 1'b1;
        mm_done = 1'b0;
        @(negedge clk);
        obs_rst_outs = {mm_start, mm_op, r_init, r_we, busy, done};
        obs_aborted = 1'b1;
        rst = 1'b0;
        return;
      end
      start = (start_busy && cyc == 5);
      if (start_busy && cyc == 5) exponent = ~e;
      md = (cyc == due) || (spur && mm_start === 1'b1);
      mm_done = md;
      @(negedge clk);
      cyc++;
    end
    obs_timeout = 1;
    mm_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mm_start, mm_op, r_init, r_we, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 000000", {mm_start, mm_op, r_init, r_we, busy, done});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mm_start, r_init, r_we, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b expected 00000", {mm_start, r_init, r_we, busy, done});
    end
  endtask

  task automatic test_basic();
    model_run(4'b1011, 3, 0);
    run_exp(4'b1011, 3, 0, 0, 0, 0);
    checks++;
    if (obs_timeout != 0 || obs_done_cyc != exp_done) begin
      errors++;
      $display("FAIL basic_done_cycle got %0d expected %0d", obs_done_cyc, exp_done);
    end
    checks++;
    if (obs_done_cyc != (SKIP ? 37 : 41)) begin
      errors++;
      $display("FAIL basic_done_plan got %0d expected %0d", obs_done_cyc, SKIP ? 37 : 41);
    end
    checks++;
    if (pack_q(obs_ops) != pack_q(exp_ops)) begin
      errors++;
      $display("FAIL basic_op_sequence got %h expected %h", pack_q(obs_ops), pack_q(exp_ops));
    end
    checks++;
    if (obs_nwe != exp_ops.size() || obs_nstart != exp_ops.size()) begin
      errors++;
      $display("FAIL basic_pulse_counts got start=%0d we=%0d expected %0d", obs_nstart, obs_nwe, exp_ops.size());
    end
    checks++;
    if (obs_ninit != 1 || obs_init_cyc != 1) begin
      errors++;
      $display("FAIL basic_r_init got count=%0d cycle=%0d expected count=1 cycle=1", obs_ninit, obs_init_cyc);
    end
    checks++;
    if (obs_busy_gap != 0 || obs_busy_after !== 1'b0 || obs_done_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_done got gap=%0d busy_after=%b done_after=%b expected 0 0 0",
               obs_busy_gap, obs_busy_after, obs_done_after);
    end
    checks++;
    if (obs_misaligned != 0 || obs_unstable != 0) begin
      errors++;
      $display("FAIL basic_handshake got misaligned=%0d unstable=%0d expected 0 0", obs_misaligned, obs_unstable);
    end
  endtask

  task automatic test_zero();
    model_run(4'b0000, 3, 0);
    run_exp(4'b0000, 3, 0, 0, 0, 0);
    checks++;
    if (obs_done_cyc != exp_done || obs_done_cyc != (SKIP ? 6 : 26)) begin
      errors++;
      $display("FAIL zero_done_cycle got %0d expected %0d", obs_done_cyc, SKIP ? 6 : 26);
    end
    checks++;
    if (obs_nstart != (SKIP ? 0 : 4) || pack_q(obs_ops) != pack_q(exp_ops)) begin
      errors++;
      $display("FAIL zero_ops got starts=%0d ops=%h expected starts=%0d ops=%h",
               obs_nstart, pack_q(obs_ops), SKIP ? 0 : 4, pack_q(exp_ops));
    end
  endtask

  task automatic test_spurious();
    model_run(4'b1011, 3, 0);
    run_exp(4'b1011, 3, 0, 1, 1, 0);
    checks++;
    if (obs_done_cyc != exp_done) begin
      errors++;
      $display("FAIL spurious_done_cycle got %0d expected %0d", obs_done_cyc, exp_done);
    end
    checks++;
    if (pack_q(obs_ops) != pack_q(exp_ops) || obs_nwe != exp_ops.size() || obs_misaligned != 0) begin
      errors++;
      $display("FAIL spurious_ops got %h we=%0d misaligned=%0d expected %h we=%0d",
               pack_q(obs_ops), obs_nwe, obs_misaligned, pack_q(exp_ops), exp_ops.size());
    end
  endtask

  task automatic test_rst_mid();
    run_exp(4'b1011, 3, 0, 0, 0, 1);
    checks++;
    if (obs_aborted != 1 || obs_rst_outs !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs got aborted=%0d outs=%b expected aborted=1 outs=000000",
               obs_aborted, obs_rst_outs);
    end
    checks++;
    if (obs_done_cyc != -1) begin
      errors++;
      $display("FAIL rst_mid_no_done got %0d expected -1", obs_done_cyc);
    end
    model_run(4'b0001, 3, 0);
    run_exp(4'b0001, 3, 0, 0, 0, 0);
    checks++;
    if (obs_done_cyc != exp_done || (!SKIP && obs_done_cyc != 31)) begin
      errors++;
      $display("FAIL rst_restart_done got %0d expected %0d", obs_done_cyc, exp_done);
    end
    checks++;
    if (pack_q(obs_ops) != pack_q(exp_ops)) begin
      errors++;
      $display("FAIL rst_restart_ops got %h expected %h", pack_q(obs_ops), pack_q(exp_ops));
    end
  endtask

  task automatic test_variable_latency();
    model_run(4'hF, 0, 1);
    run_exp(4'hF, 0, 1, 0, 0, 0);
    checks++;
    if (obs_unstable != 0) begin
      errors++;
      $display("FAIL varlat_op_stable got %0d unstable cycles expected 0", obs_unstable);
    end
    checks++;
    if (obs_nwe != obs_nstart || obs_misaligned != 0 || obs_nwe != exp_ops.size()) begin
      errors++;
      $display("FAIL varlat_we_per_done got we=%0d starts=%0d misaligned=%0d expected %0d %0d 0",
               obs_nwe, obs_nstart, obs_misaligned, exp_ops.size(), exp_ops.size());
    end
    checks++;
    if (obs_done_cyc != exp_done) begin
      errors++;
      $display("FAIL varlat_done_cycle got %0d expected %0d", obs_done_cyc, exp_done);
    end
  endtask

  task automatic test_random();
    logic [EXP_W-1:0] e;
    int l;
    for (int n = 0; n < 16; n++) begin
      e = EXP_W'($urandom);
      l = $urandom_range(1, 6);
      model_run(e, l, 0);
      run_exp(e, l, 0, 0, 0, 0);
      checks++;
      if (obs_done_cyc != exp_done || pack_q(obs_ops) != pack_q(exp_ops) ||
          obs_nwe != exp_ops.size() || obs_unstable != 0) begin
        errors++;
        $display("FAIL random_e%h_l%0d got done=%0d ops=%h we=%0d expected done=%0d ops=%h we=%0d",
                 e, l, obs_done_cyc, pack_q(obs_ops), obs_nwe, exp_done, pack_q(exp_ops), exp_ops.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    // Each run starts on the IDLE cycle that immediately follows FINISH.
    model_run(4'b0110, 2, 0);
    run_exp(4'b0110, 2, 0, 0, 0, 0);
    checks++;
    if (obs_done_cyc != exp_done) begin
      errors++;
      $display("FAIL b2b_first got %0d expected %0d", obs_done_cyc, exp_done);
    end
    model_run(4'b1001, 4, 0);
    run_exp(4'b1001, 4, 0, 0, 0, 0);
    checks++;
    if (obs_done_cyc != exp_done || pack_q(obs_ops) != pack_q(exp_ops)) begin
      errors++;
      $display("FAIL b2b_second got done=%0d ops=%h expected done=%0d ops=%h",
               obs_done_cyc, pack_q(obs_ops), exp_done, pack_q(exp_ops));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_spurious();
    test_rst_mid();
    test_variable_latency();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
